booth_div: RTL and testbench

Sequential 32-bit signed divider for the datapath's DIV instruction; the inverse counterpart of the combinational Booth multiplier. Takes dividend X and divisor Y, produces quotient on Z_Low and remainder on Z_High so the control unit loads LO/HI exactly as for MUL. Uses radix-2 non-restoring division on operand magnitudes with a start/done handshake.

---
 rtl/booth_div.sv | 83 ++++++++
 tb/tb_booth_div.sv | 131 +++++++++++++
 2 files changed

// File: rtl/booth_div.sv
// booth_div: sequential 32-bit signed non-restoring divider (quotient on Z_Low, remainder on Z_High); define BOOTH_DIV_ZERO_TRAP_EN to trap zero divisors
module booth_div (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] X,
  input  logic [31:0] Y,
  output logic        busy,
  output logic        done,
  output logic [31:0] Z_Low,
  output logic [31:0] Z_High,
  output logic        div_zero
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PREP = 3'd1;
  localparam logic [2:0] RUN  = 3'd2;
  localparam logic [2:0] FIX  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;
  logic [2:0]  state;
  logic [31:0] xr, yr, q, ay;
  logic [32:0] r, rs, rn, rf;
  logic [4:0]  cnt;
  logic        qsign, rsign;
  assign busy = (state == PREP) || (state == RUN) || (state == FIX);
  assign done = (state == DONE);
`ifndef BOOTH_DIV_ZERO_TRAP_EN
  assign div_zero = 1'b0;
`endif
  // one non-restoring step on the 33-bit partial remainder, plus the final restore
  always_comb begin
    rs = {r[31:0], q[31]};
    rn = r[32] ? rs + {1'b0, ay} : rs - {1'b0, ay};
    rf = r[32] ? r + {1'b0, ay} : r;
  end
  // control FSM and datapath registers; operands are latched so X/Y may change after accept
  always_ff @(posedge clock) begin
    if (!clear) begin
      state  <= IDLE;
      Z_Low  <= '0;
      Z_High <= '0;
`ifdef BOOTH_DIV_ZERO_TRAP_EN
      div_zero <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          xr    <= X;
          yr    <= Y;
          state <= PREP;
`ifdef BOOTH_DIV_ZERO_TRAP_EN
          div_zero <= (Y == 32'd0);
          if (Y == 32'd0) begin
            state  <= DONE;
            Z_Low  <= '1;
            Z_High <= X;
          end
`endif
        end
        PREP: begin
          q     <= xr[31] ? -xr : xr;
          ay    <= yr[31] ? -yr : yr;
          qsign <= xr[31] ^ yr[31];
          rsign <= xr[31];
          r     <= '0;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          r   <= rn;
          q   <= {q[30:0], ~rn[32]};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          Z_Low  <= qsign ? -q : q;
          Z_High <= rsign ? -rf[31:0] : rf[31:0];
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_div.sv
// tb_booth_div: directed and random checks of booth_div against a plain-arithmetic division model
module tb_booth_div;
  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [31:0] X = '0;
  logic [31:0] Y = '0;
  logic        busy, done, div_zero;
  logic [31:0] Z_Low, Z_High;
  int tests = 0;
  int fails = 0;

  booth_div dut (
    .clock(clock), .clear(clear), .start(start), .X(X), .Y(Y),
    .busy(busy), .done(done), .Z_Low(Z_Low), .Z_High(Z_High), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic z, output int lat);
    longint xs, ys;
    xs = $signed(x);
    ys = $signed(y);
    if (y == 32'd0) begin
`ifdef BOOTH_DIV_ZERO_TRAP_EN
      q = 32'hFFFFFFFF; r = x; z = 1'b1; lat = 1;
`else
      q = x[31] ? 32'h00000001 : 32'hFFFFFFFF; r = x; z = 1'b0; lat = 35;
`endif
    end else begin
      q = 32'(xs / ys);
      r = 32'(xs % ys);
      z = 1'b0;
      lat = 35;
    end
  endtask

  task automatic div_op(input string tag, input logic [31:0] x, input logic [31:0] y, input bit poke);
    logic [31:0] eq, er;
    logic ez;
    int lat, n, nb;
    model(x, y, eq, er, ez, lat);
    X = x; Y = y; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; X = $urandom; Y = $urandom;
    n = 0; nb = 0;
    while (!done && n < 100) begin
      nb += int'(busy);
      start = poke && (n == 9 || n == 33);
      @(posedge clock); #1;
      start = 1'b0;
      n++;
    end
    chk({tag, " done seen"}, 32'(done), 32'd1);
    chk({tag, " latency"}, n + 1, lat);
    chk({tag, " busy cycles"}, nb, lat - 1);
    chk({tag, " busy in done"}, 32'(busy), 32'd0);
    chk({tag, " quotient"}, Z_Low, eq);
    chk({tag, " remainder"}, Z_High, er);
    chk({tag, " div_zero"}, 32'(div_zero), 32'(ez));
    start = poke;
    @(posedge clock); #1;
    start = 1'b0;
    chk({tag, " done pulse"}, 32'(done), 32'd0);
    chk({tag, " idle after"}, 32'(busy), 32'd0);
    chk({tag, " quotient held"}, Z_Low, eq);
  endtask

  initial begin
    int nd;
    logic [31:0] rx, ry;
    repeat (3) @(posedge clock);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset div_zero", 32'(div_zero), 32'd0);
    chk("reset Z_Low", Z_Low, 32'd0);
    chk("reset Z_High", Z_High, 32'd0);
    clear = 1'b1;
    @(posedge clock); #1;
    div_op("basic", 32'd100, 32'd7, 1'b0);
    div_op("neg/pos", -32'sd100, 32'd7, 1'b0);
    div_op("pos/neg", 32'd100, -32'sd7, 1'b0);
    div_op("neg/neg", -32'sd100, -32'sd7, 1'b0);
    div_op("min/-1", 32'h80000000, 32'hFFFFFFFF, 1'b0);
    div_op("min/1", 32'h80000000, 32'd1, 1'b0);
    div_op("5/max", 32'd5, 32'h7FFFFFFF, 1'b0);
    div_op("zero div", -32'sd9, 32'd0, 1'b0);
    div_op("after zero", 32'd0, 32'd5, 1'b0);
    div_op("handshake", 32'd1000, 32'd33, 1'b1);
    div_op("next accept", 32'd77, -32'sd5, 1'b0);
    X = 32'd12345; Y = 32'd67; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (19) @(posedge clock);
    #1;
    clear = 1'b0;
    @(posedge clock); #1;
    clear = 1'b1;
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset done", 32'(done), 32'd0);
    chk("midreset Z_Low", Z_Low, 32'd0);
    chk("midreset Z_High", Z_High, 32'd0);
    nd = 0;
    repeat (50) begin
      @(posedge clock); #1;
      nd += int'(done);
    end
    chk("midreset no done", nd, 0);
    div_op("post reset", 32'd12345, 32'd67, 1'b0);
    for (int i = 0; i < 40; i++) begin
      rx = $urandom;
      ry = $urandom;
      if (i % 4 == 1) ry = ry >> $urandom_range(31, 16);
      if (i % 10 == 7) ry = 32'd0;
      div_op("random", rx, ry, 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
